bch_encode_serial: RTL and testbench



---
 rtl/bch_encode_serial.sv | 147 ++++++++++++++
 tb/tb_bch_encode_serial.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bch_encode_serial.sv
// Systematic serial BCH encoder: message bits pass through MSB first, then the
// generator-polynomial remainder follows. Optional error injection: BCH_ENC_ERR_INJECT_EN.
module bch_encode_serial #(
  parameter int unsigned    M         = 4,
  parameter int unsigned    T         = 2,
  parameter int unsigned    DATA_BITS = 7,
  parameter logic [M*T-1:0] GEN       = 8'hD1
) (
  input  logic clk,
  input  logic rst_n,
`ifdef BCH_ENC_ERR_INJECT_EN
  input  logic err_inject,
`endif
  input  logic start,
  input  logic data_in,
  input  logic in_valid,
  output logic in_ready,
  output logic out_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_first,
  output logic out_last,
  output logic busy
);

  localparam int unsigned ECC_BITS = M * T;
  localparam int unsigned CNT_MAX  = (DATA_BITS > ECC_BITS) ? DATA_BITS : ECC_BITS;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_ECC} state_e;

  state_e              state_q, state_d;
  logic [ECC_BITS-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                out_bit_q, out_bit_d;
  logic                out_valid_q, out_valid_d;
  logic                out_first_q, out_first_d;
  logic                out_last_q, out_last_d;
  logic                in_ready_c;
  logic                busy_c;
  logic                slot_c;
  logic                fb_c;
  logic                inj_c;

`ifdef BCH_ENC_ERR_INJECT_EN
  assign inj_c = err_inject;
`else
  assign inj_c = 1'b0;
`endif

  assign busy_c = (state_q != S_IDLE) || out_valid_q;
  assign slot_c = !out_valid_q || out_ready;
  // Feedback always uses the true data bit so the remainder is unaffected by injection.
  assign fb_c   = data_in ^ lfsr_q[ECC_BITS-1];

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    cnt_d       = cnt_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    in_ready_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (slot_c) begin
          out_valid_d = 1'b0;
        end
        if (start && !busy_c) begin
          state_d = S_DATA;
          lfsr_d  = '0;
          cnt_d   = '0;
        end
      end

      S_DATA: begin
        in_ready_c = slot_c;
        if (in_valid && slot_c) begin
          out_bit_d   = data_in ^ inj_c;
          out_valid_d = 1'b1;
          out_first_d = (cnt_q == '0);
          out_last_d  = 1'b0;
          lfsr_d      = {lfsr_q[ECC_BITS-2:0], 1'b0} ^ (fb_c ? GEN : '0);
          if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
            state_d = S_ECC;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (slot_c) begin
          out_valid_d = 1'b0;
        end
      end

      S_ECC: begin
        if (slot_c) begin
          out_bit_d   = lfsr_q[ECC_BITS-1] ^ inj_c;
          out_valid_d = 1'b1;
          out_first_d = 1'b0;
          out_last_d  = (cnt_q == CNT_W'(ECC_BITS - 1));
          lfsr_d      = {lfsr_q[ECC_BITS-2:0], 1'b0};
          if (cnt_q == CNT_W'(ECC_BITS - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      lfsr_q      <= '0;
      cnt_q       <= '0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      cnt_q       <= cnt_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign busy      = busy_c;

endmodule

// File: tb/tb_bch_encode_serial.sv
// Scoreboard bench for bch_encode_serial: reference codewords from polynomial
// long division, random messages, random/patterned backpressure, mid-word reset.
module tb_bch_encode_serial;

  localparam int unsigned K  = 7;
  localparam int unsigned E  = 8;
  localparam int unsigned NW = K + E;
  localparam logic [7:0]  G  = 8'hD1;

  logic clk, rst_n, start, data_in, in_valid, in_ready;
  logic out_bit, out_valid, out_ready, out_first, out_last, busy;
`ifdef BCH_ENC_ERR_INJECT_EN
  logic err_inject;
`endif

  bch_encode_serial #(.M(4), .T(2), .DATA_BITS(K), .GEN(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef BCH_ENC_ERR_INJECT_EN
    .err_inject(err_inject),
`endif
    .start     (start),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic b; logic f; logic l;} exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  int rdy_mode = 0;
  int pidx = 0;
  logic [3:0] pat = 4'b1001;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Codeword = m(x)*x^E + (m(x)*x^E mod g(x)), MSB first.
  function automatic logic [14:0] ref_codeword(input logic [6:0] msg);
    logic [14:0] r;
    logic [14:0] g;
    r = {msg, 8'h00};
    g = 15'({1'b1, G});
    for (int i = 14; i >= 8; i--)
      if (r[i]) r = r ^ (g << (i - 8));
    return {msg, r[7:0]};
  endfunction

  task automatic push_word(input logic [6:0] msg);
    logic [14:0] cw;
    cw = ref_codeword(msg);
    for (int j = 0; j < NW; j++)
      exp_q.push_back('{b: cw[14-j], f: (j == 0), l: (j == NW - 1)});
  endtask

  // Downstream ready: always, fixed 1,0,0,1 pattern, or random.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = pat[pidx % 4]; pidx++; end
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  logic stall_prev = 1'b0;
  logic held_bit, held_first, held_last;

  // Monitor: pop expected entry on each accepted output bit.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        check("hold_bit", 32'(out_bit), 32'(held_bit));
        check("hold_first", 32'(out_first), 32'(held_first));
        check("hold_last", 32'(out_last), 32'(held_last));
      end
      if (out_valid && !out_ready)
        check("in_ready_stall", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=valid required=idle (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("out_bit", 32'(out_bit), 32'(e.b));
          check("out_first", 32'(out_first), 32'(e.f));
          check("out_last", 32'(out_last), 32'(e.l));
          if (out_first) first_cyc = cyc;
          if (out_last) last_cyc = cyc;
        end
      end
      stall_prev = out_valid && !out_ready;
      held_bit   = out_bit;
      held_first = out_first;
      held_last  = out_last;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Send one message; returns early after abort_at bits when abort_at >= 0.
  task automatic send_word(input logic [6:0] msg, input int gap, input bit poke, input int abort_at);
    int i = 0;
    int n = 0;
    wait_idle();
    push_word(msg);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (i < K && n < 1000) begin
      if (abort_at == i) break;
      in_valid = ($urandom_range(0, 99) >= gap);
      data_in  = msg[K-1-i];
      start    = poke && (i == 3);
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (n >= 1000) check("send_timeout", 32'(i), 32'(K));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_bit"}, 32'(out_bit), 32'd0);
    check({tag, "_out_first"}, 32'(out_first), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; data_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
`ifdef BCH_ENC_ERR_INJECT_EN
    err_inject = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_rst");

    // All-zero message, continuous ready: 15 back-to-back bits, busy drops after.
    rdy_mode = 0;
    send_word(7'h00, 0, 1'b0, -1);
    drain();
    #1;
    check("busy_after_last", 32'(busy), 32'd0);
    check("consecutive_span", 32'(last_cyc - first_cyc), 32'(NW - 1));

    send_word(7'h7F, 0, 1'b0, -1);
    drain();
    send_word(7'h01, 0, 1'b0, -1);
    drain();

    // Fixed backpressure pattern.
    rdy_mode = 1;
    send_word(7'h01, 0, 1'b0, -1);
    drain();
    send_word(7'h5A, 20, 1'b0, -1);
    drain();

    // Random messages, random gaps and random backpressure.
    rdy_mode = 2;
    for (int w = 0; w < 40; w++)
      send_word(7'($urandom_range(0, 127)), 30, ($urandom_range(0, 3) == 0), -1);
    drain();

    // Ignored start mid-word, then reset at data bit 4.
    rdy_mode = 0;
    send_word(7'h01, 0, 1'b1, 4);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("abort_rel");
    send_word(7'h01, 0, 1'b0, -1);
    drain();
    #1;
    check("busy_end", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
